nn_layer_sequencer: RTL and testbench

Initiator side of the layer start/done handshake. It accepts one input sample on a valid/ready port and holds it as layer 0's operand. It then pulses start to each sequential linear layer in order, waits for each layer's done, and presents the final layer's result on a valid/ready output port. A per-layer watchdog traps layers that never assert done.

---
 rtl/nn_layer_sequencer_if.sv | 26 ++
 rtl/nn_layer_sequencer.sv | 131 +++++++++++++
 tb/tb_nn_layer_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_sequencer_if.sv
// Sample-in / result-out stream bundle for the layer sequencer.
//   in_valid/in_data/in_ready    : input sample handshake
//   out_valid/out_data/out_ready : final result handshake
// master = environment side (produces samples, consumes results)
// slave  = sequencer side
interface nn_layer_sequencer_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 8
);
   logic             in_valid;
   logic [IN_W-1:0]  in_data;
   logic             in_ready;
   logic             out_valid;
   logic [OUT_W-1:0] out_data;
   logic             out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Initiator for a chain of start/done layers. Accepts one sample, pulses
// start to each layer in turn, waits for its done, then presents the last
// layer's result. A per-layer watchdog traps a layer that never finishes.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : sample input and result output handshakes
//   layer_in     : held sample, operand of layer 0
//   layer_start  : one-hot start pulse, bit k -> layer k
//   layer_done   : done from each layer
//   res_in       : result bus from the last layer
//   busy         : high in START/WAIT/OUT
//   error        : watchdog flag, held until err_clr
//   err_clr      : clears error and returns to IDLE
//
// state | meaning
// IDLE  | ready for a new sample
// START | one-cycle start pulse to layer idx
// WAIT  | waiting for done of layer idx, watchdog running
// OUT   | result held until downstream accepts
// ERR   | watchdog expired, waiting for err_clr
module nn_layer_sequencer #(
   parameter int NUM_LAYERS     = 3,
   parameter int IN_W           = 8,
   parameter int OUT_W          = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   nn_layer_sequencer_if.slave   bus,
   output logic [IN_W-1:0]       layer_in,
   output logic [NUM_LAYERS-1:0] layer_start,
   input  logic [NUM_LAYERS-1:0] layer_done,
   input  logic [OUT_W-1:0]      res_in,
   output logic                  busy,
   output logic                  error,
   input  logic                  err_clr
);
   localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_OUT   = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [IN_W-1:0]  layer_in_q, layer_in_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      timer_d    = timer_q;
      layer_in_d = layer_in_q;
      out_data_d = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               layer_in_d = bus.in_data;
               idx_d      = '0;
               state_d    = S_START;
            end
         end
         S_START: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done wins over the watchdog on the last allowed cycle
            if (layer_done[idx_q]) begin
               if (idx_q == LAST_IDX) begin
                  out_data_d = res_in;
                  state_d    = S_OUT;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_START;
               end
            end else begin
               timer_d = timer_q + 1'b1;
               if (timer_q == TMR_LAST) begin
                  state_d = S_ERR;
               end
            end
         end
         S_OUT: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         S_ERR: begin
            if (err_clr) begin
               idx_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         timer_q    <= '0;
         layer_in_q <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         layer_in_q <= layer_in_d;
         out_data_q <= out_data_d;
      end
   end

   // error is the ERR state itself, so err_clr and rst both clear it
   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_OUT);
   assign bus.out_data  = out_data_q;
   assign layer_in      = layer_in_q;
   assign layer_start   = (state_q == S_START) ? (NUM_LAYERS'(1) << idx_q) : '0;
   assign busy          = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_OUT);
   assign error         = (state_q == S_ERR);
endmodule

// File: tb/tb_nn_layer_sequencer.sv
module tb_nn_layer_sequencer;
   logic       clk;
   logic       rst;
   logic [7:0] layer_in;
   logic [2:0] layer_start;
   logic [2:0] layer_done;
   logic [7:0] res_in;
   logic       busy;
   logic       error;
   logic       err_clr;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // mock layers: done asserted lat[k] cycles after the start pulse (0 = never)
   int         lat  [3];
   int         mcnt [3];
   logic       mact [3];
   logic [2:0] stray;

   nn_layer_sequencer_if #(.IN_W(8), .OUT_W(8)) bus ();

   nn_layer_sequencer #(
      .NUM_LAYERS(3), .IN_W(8), .OUT_W(8), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .layer_in   (layer_in),
      .layer_start(layer_start),
      .layer_done (layer_done),
      .res_in     (res_in),
      .busy       (busy),
      .error      (error),
      .err_clr    (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            mact[k] <= 1'b0;
            mcnt[k] <= 0;
         end else if (layer_start[k]) begin
            mact[k] <= 1'b1;
            mcnt[k] <= 1;
         end else if (mact[k]) begin
            if (mcnt[k] == lat[k]) mact[k] <= 1'b0;
            else mcnt[k] <= mcnt[k] + 1;
         end
      end
   end

   always_comb begin
      layer_done = stray;
      for (int k = 0; k < 3; k++)
         if (mact[k] && mcnt[k] == lat[k]) layer_done[k] = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // what: 0 = any start pulse, 1 = out_valid, 2 = error
   task automatic wait_for(input int what, input int budget, input string tag);
      int   n;
      logic hit;
      n = 0;
      do begin
         step();
         n++;
         hit = (what == 0) ? (layer_start != 3'b000) :
               (what == 1) ? bus.out_valid : error;
      end while (!hit && n < budget);
      check({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic accept(input logic [7:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      cyc = 0;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic run_to_out(input string tag, input logic [7:0] res, input logic [7:0] smp);
      wait_for(0, 40, {tag, "_s1"});
      check({tag, "_s1_vec"}, 32'(layer_start), 32'h2);
      check({tag, "_s1_cyc"}, cyc, 18);
      wait_for(0, 40, {tag, "_s2"});
      check({tag, "_s2_vec"}, 32'(layer_start), 32'h4);
      check({tag, "_s2_cyc"}, cyc, 35);
      wait_for(1, 40, {tag, "_out"});
      check({tag, "_out_cyc"}, cyc, 52);
      check({tag, "_out_data"}, 32'(bus.out_data), 32'(res));
      check({tag, "_layer_in"}, 32'(layer_in), 32'(smp));
   endtask

   initial begin
      rst           = 1'b1;
      err_clr       = 1'b0;
      stray         = 3'b000;
      res_in        = 8'h5A;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) lat[k] = 16;
      step();
      step();
      check("rst_start", 32'(layer_start), 32'h0);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_error", 32'(error), 32'h0);
      check("rst_in_ready", 32'(bus.in_ready), 32'h1);
      check("rst_layer_in", 32'(layer_in), 32'h0);
      check("rst_out_data", 32'(bus.out_data), 32'h0);
      rst = 1'b0;

      // nominal run with backpressure
      accept(8'h33);
      check("nom_s0_vec", 32'(layer_start), 32'h1);
      check("nom_s0_busy", 32'(busy), 32'h1);
      check("nom_in_ready", 32'(bus.in_ready), 32'h0);
      run_to_out("nom", 8'h5A, 8'h33);
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_out_valid", 32'(bus.out_valid), 32'h1);
         check("bp_out_data", 32'(bus.out_data), 32'h5A);
         check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      end
      bus.out_ready = 1'b1;
      step();
      check("bp_drain_valid", 32'(bus.out_valid), 32'h0);
      check("bp_drain_in_ready", 32'(bus.in_ready), 32'h1);
      check("bp_drain_busy", 32'(busy), 32'h0);
      check("bp_layer_in_held", 32'(layer_in), 32'h33);

      // timeout on layer 1
      lat[1] = 0;
      accept(8'h44);
      wait_for(0, 40, "to_s1");
      check("to_s1_cyc", cyc, 18);
      wait_for(2, 100, "to_err");
      check("to_err_cyc", cyc, 83);
      check("to_err_busy", 32'(busy), 32'h0);
      check("to_err_in_ready", 32'(bus.in_ready), 32'h0);
      step();
      step();
      step();
      check("to_no_start", 32'(layer_start), 32'h0);
      check("to_err_sticky", 32'(error), 32'h1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("to_clr_error", 32'(error), 32'h0);
      check("to_clr_in_ready", 32'(bus.in_ready), 32'h1);
      lat[1] = 16;

      // layer 0 done on its 64th WAIT cycle
      lat[0] = 64;
      accept(8'h55);
      wait_for(0, 100, "bd_s1");
      check("bd_s1_vec", 32'(layer_start), 32'h2);
      check("bd_s1_cyc", cyc, 66);
      check("bd_no_error", 32'(error), 32'h0);
      wait_for(1, 60, "bd_out");
      check("bd_out_cyc", cyc, 100);
      step();
      lat[0] = 16;

      // stray done pulses
      res_in = 8'hA7;
      accept(8'h12);
      stray = 3'b001;
      check("st_s0_vec", 32'(layer_start), 32'h1);
      step();
      stray = 3'b000;
      check("st_wait_busy", 32'(busy), 32'h1);
      step();
      step();
      step();
      stray = 3'b100;
      step();
      stray = 3'b000;
      run_to_out("st", 8'hA7, 8'h12);
      step();

      // reset during WAIT on layer 1
      res_in = 8'h3C;
      accept(8'h77);
      wait_for(0, 40, "rm_s1");
      check("rm_s1_cyc", cyc, 18);
      for (int i = 0; i < 5; i++) step();
      check("rm_busy_before", 32'(busy), 32'h1);
      rst = 1'b1;
      step();
      check("rm_start", 32'(layer_start), 32'h0);
      check("rm_busy", 32'(busy), 32'h0);
      check("rm_out_valid", 32'(bus.out_valid), 32'h0);
      check("rm_layer_in", 32'(layer_in), 32'h0);
      rst = 1'b0;
      check("rm_in_ready", 32'(bus.in_ready), 32'h1);
      accept(8'h21);
      check("rm2_s0_vec", 32'(layer_start), 32'h1);
      run_to_out("rm2", 8'h3C, 8'h21);
      step();
      check("rm2_idle", 32'(bus.in_ready), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
